// File: rtl/riscv_mc.sv
// Multi-cycle RV32I-subset core (FETCH/DECODE/EXEC/MEM/WB/HALT) with its regfile and ALU.
// 3 to 5 cycles per instruction at zero wait; each memory wait cycle holds the request and adds one cycle.
package riscv_mc_pkg;
    typedef enum logic [2:0] {AluAdd, AluSub, AluAnd, AluOr, AluSlt} alu_op_e;
endpackage

module regfile #(
    parameter int XLen = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_we,
    input  logic [4:0]      i_waddr,
    input  logic [XLen-1:0] i_wdata,
    input  logic [4:0]      i_raddr_a,
    input  logic [4:0]      i_raddr_b,
    output logic [XLen-1:0] o_rdata_a,
    output logic [XLen-1:0] o_rdata_b
);
    logic [XLen-1:0] r_mem [32];

    // x0 is never written, so it always reads back as zero
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 32; i++) r_mem[i] <= '0;
        end else if (i_we && (i_waddr != 5'd0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];
endmodule

module alu #(
    parameter int XLen = 32
) (
    input  riscv_mc_pkg::alu_op_e i_op,
    input  logic [XLen-1:0]       i_a,
    input  logic [XLen-1:0]       i_b,
    output logic [XLen-1:0]       o_y
);
    always_comb begin
        o_y = i_a + i_b;
        case (i_op)
            riscv_mc_pkg::AluSub: o_y = i_a - i_b;
            riscv_mc_pkg::AluAnd: o_y = i_a & i_b;
            riscv_mc_pkg::AluOr:  o_y = i_a | i_b;
            riscv_mc_pkg::AluSlt: o_y = {{(XLen-1){1'b0}}, $signed(i_a) < $signed(i_b)};
            default:              o_y = i_a + i_b;
        endcase
    end
endmodule

module riscv_mc #(
    parameter int          XLen     = 32,
    parameter int          ILen     = 32,
    parameter logic [31:0] BootAddr = 32'h0000_0000
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    output logic            pmem_req_o,
    output logic [XLen-1:0] pmem_addr_o,
    input  logic            pmem_rvalid_i,
    input  logic [ILen-1:0] pmem_rdata_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLen-1:0] dmem_addr_o,
    output logic [XLen-1:0] dmem_wdata_o,
    input  logic            dmem_rvalid_i,
    input  logic [XLen-1:0] dmem_rdata_i,
    output logic            retire_o,
    output logic            halt_o
);
    import riscv_mc_pkg::*;

    if (XLen != 32 || ILen != 32) begin : g_bad_width
        $error("riscv_mc supports only XLen = ILen = 32");
    end
    if (BootAddr[1:0] != 2'b00) begin : g_bad_boot
        $error("riscv_mc BootAddr must be word-aligned");
    end

    typedef enum logic [2:0] {SFetch, SDecode, SExec, SMem, SWb, SHalt} state_e;

    state_e          r_state, w_state_nxt;
    logic [ILen-1:0] r_ir;
    logic [XLen-1:0] r_pc, r_a, r_b, r_imm, r_res;

    logic [6:0]      w_opc, w_f7;
    logic [2:0]      w_f3;
    logic            w_f3_alu, w_is_r, w_is_i, w_is_lw, w_is_sw, w_is_br;
    logic            w_is_jal, w_is_jalr, w_is_lui, w_is_auipc, w_legal, w_ctl, w_link;
    logic [XLen-1:0] w_imm, w_alu_b, w_alu_y, w_rs1, w_rs2, w_pc4, w_pc_imm, w_next_pc, w_rd_wdata;
    logic            w_taken, w_pc_bad, w_rf_we;
    alu_op_e         w_alu_op;

    assign w_opc      = r_ir[6:0];
    assign w_f3       = r_ir[14:12];
    assign w_f7       = r_ir[31:25];
    assign w_f3_alu   = (w_f3 == 3'b000) || (w_f3 == 3'b111) || (w_f3 == 3'b110) || (w_f3 == 3'b010);
    assign w_is_r     = (w_opc == 7'b0110011) &&
                        (((w_f7 == 7'b0000000) && w_f3_alu) || ((w_f7 == 7'b0100000) && (w_f3 == 3'b000)));
    assign w_is_i     = (w_opc == 7'b0010011) && w_f3_alu;
    assign w_is_lw    = (w_opc == 7'b0000011) && (w_f3 == 3'b010);
    assign w_is_sw    = (w_opc == 7'b0100011) && (w_f3 == 3'b010);
    assign w_is_br    = (w_opc == 7'b1100011) && (w_f3[2:1] == 2'b00);
    assign w_is_jal   = (w_opc == 7'b1101111);
    assign w_is_jalr  = (w_opc == 7'b1100111) && (w_f3 == 3'b000);
    assign w_is_lui   = (w_opc == 7'b0110111);
    assign w_is_auipc = (w_opc == 7'b0010111);
    assign w_link     = w_is_jal || w_is_jalr || w_is_lui || w_is_auipc;
    assign w_ctl      = w_is_br || w_link;
    assign w_legal    = w_is_r || w_is_i || w_is_lw || w_is_sw || w_ctl;

    always_comb begin
        w_imm = {{20{r_ir[31]}}, r_ir[31:20]};
        if (w_is_sw)                     w_imm = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
        else if (w_is_br)                w_imm = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
        else if (w_is_lui || w_is_auipc) w_imm = {r_ir[31:12], 12'b0};
        else if (w_is_jal)               w_imm = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
    end

    // Only R/I ALU instructions select by funct3; addresses and jalr targets use add
    always_comb begin
        w_alu_op = AluAdd;
        if (w_is_r || w_is_i) begin
            case (w_f3)
                3'b000:  w_alu_op = (w_is_r && w_f7[5]) ? AluSub : AluAdd;
                3'b111:  w_alu_op = AluAnd;
                3'b110:  w_alu_op = AluOr;
                3'b010:  w_alu_op = AluSlt;
                default: w_alu_op = AluAdd;
            endcase
        end
    end

    assign w_alu_b = w_is_r ? r_b : r_imm;

    alu #(.XLen(XLen)) u_alu (.i_op(w_alu_op), .i_a(r_a), .i_b(w_alu_b), .o_y(w_alu_y));

    assign w_pc4     = r_pc + 32'd4;
    assign w_pc_imm  = r_pc + r_imm;
    assign w_taken   = w_f3[0] ? (r_a != r_b) : (r_a == r_b);
    assign w_next_pc = (w_is_jal || (w_is_br && w_taken)) ? w_pc_imm :
                       w_is_jalr ? {w_alu_y[XLen-1:1], 1'b0} : w_pc4;
    assign w_pc_bad  = (w_next_pc[1:0] != 2'b00);

    assign w_rf_we    = (r_state == SWb) || ((r_state == SExec) && w_link && !w_pc_bad);
    assign w_rd_wdata = (r_state == SWb) ? r_res : w_is_lui ? r_imm : w_is_auipc ? w_pc_imm : w_pc4;

    regfile #(.XLen(XLen)) u_rf (
        .i_clk(clk_i), .i_rst_n(rst_ni), .i_we(w_rf_we), .i_waddr(r_ir[11:7]), .i_wdata(w_rd_wdata),
        .i_raddr_a(r_ir[19:15]), .i_raddr_b(r_ir[24:20]), .o_rdata_a(w_rs1), .o_rdata_b(w_rs2)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) r_state <= SFetch;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SFetch:  if (pmem_rvalid_i) w_state_nxt = SDecode;
            SDecode: w_state_nxt = w_legal ? SExec : SHalt;
            SExec: begin
                if (w_is_lw || w_is_sw) w_state_nxt = (w_alu_y[1:0] != 2'b00) ? SHalt : SMem;
                else if (w_ctl)         w_state_nxt = w_pc_bad ? SHalt : SFetch;
                else                    w_state_nxt = SWb;
            end
            SMem:    if (dmem_rvalid_i) w_state_nxt = w_is_sw ? SFetch : SWb;
            SWb:     w_state_nxt = SFetch;
            default: w_state_nxt = SHalt;
        endcase
    end

    // Outputs are forced low while reset is held, which also aborts any access in flight
    always_comb begin
        pmem_req_o   = 1'b0;
        pmem_addr_o  = '0;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_addr_o  = '0;
        dmem_wdata_o = '0;
        retire_o     = 1'b0;
        halt_o       = 1'b0;
        if (rst_ni) begin
            case (r_state)
                SFetch: begin
                    pmem_req_o  = 1'b1;
                    pmem_addr_o = r_pc;
                end
                SExec: retire_o = w_ctl && !w_pc_bad;
                SMem: begin
                    dmem_req_o   = 1'b1;
                    dmem_we_o    = w_is_sw;
                    dmem_addr_o  = {r_res[XLen-1:2], 2'b00};
                    dmem_wdata_o = r_b;
                    retire_o     = dmem_rvalid_i && w_is_sw;
                end
                SWb:    retire_o = 1'b1;
                SHalt:  halt_o = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_pc  <= BootAddr;
            r_ir  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_imm <= '0;
            r_res <= '0;
        end else begin
            case (r_state)
                SFetch: if (pmem_rvalid_i) r_ir <= pmem_rdata_i;
                SDecode: begin
                    r_a   <= w_rs1;
                    r_b   <= w_rs2;
                    r_imm <= w_imm;
                end
                SExec: begin
                    if (!w_ctl)              r_res <= w_alu_y;
                    if (w_ctl && !w_pc_bad)  r_pc  <= w_next_pc;
                end
                SMem: begin
                    if (dmem_rvalid_i && w_is_sw)  r_pc  <= w_pc4;
                    if (dmem_rvalid_i && !w_is_sw) r_res <= dmem_rdata_i;
                end
                SWb:    r_pc <= w_pc4;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_mc.sv
// Directed bench for riscv_mc: instruction/data memory models with programmable wait states.
module tb_riscv_mc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pmem_req, pmem_rvalid, dmem_req, dmem_we, dmem_rvalid, retire, halt;
    logic [31:0] pmem_addr, pmem_rdata, dmem_addr, dmem_wdata, dmem_rdata;

    logic [31:0] imem [0:63];
    logic [31:0] dmem [0:63];
    int          p_wait = 0;
    int          d_wait = 0;
    int          p_cnt  = 0;
    int          d_cnt  = 0;

    int          n_chk = 0;
    int          n_err = 0;

    int          ret_q[$];
    logic [31:0] fetch_q[$];
    int          halt_cyc, first_req_cyc, st_cycles;
    logic [31:0] st_addr_first, st_data_first, st_addr_last;

    always #5 clk = ~clk;

    riscv_mc u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .pmem_req_o(pmem_req), .pmem_addr_o(pmem_addr), .pmem_rvalid_i(pmem_rvalid), .pmem_rdata_i(pmem_rdata),
        .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr), .dmem_wdata_o(dmem_wdata),
        .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata),
        .retire_o(retire), .halt_o(halt)
    );

    // Memories answer after p_wait/d_wait cycles of a held request
    assign pmem_rvalid = pmem_req && (p_cnt == p_wait);
    assign pmem_rdata  = imem[pmem_addr[7:2]];
    assign dmem_rvalid = dmem_req && (d_cnt == d_wait);
    assign dmem_rdata  = dmem[dmem_addr[7:2]];

    always @(posedge clk) begin
        p_cnt <= (!pmem_req || pmem_rvalid) ? 0 : p_cnt + 1;
        d_cnt <= (!dmem_req || dmem_rvalid) ? 0 : d_cnt + 1;
        if (dmem_rvalid && dmem_we) dmem[dmem_addr[7:2]] <= dmem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int ret_at(input int i);
        return (i < ret_q.size()) ? ret_q[i] : -1;
    endfunction

    function automatic logic [31:0] fetch_at(input int i);
        return (i < fetch_q.size()) ? fetch_q[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) begin
            imem[i] = 32'h0;
            dmem[i] = 32'h0;
        end
    endtask

    // One reset edge; outputs are checked low inside the reset cycle
    task automatic do_reset(input string tag);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check({tag, "_rst_preq"}, {31'b0, pmem_req}, 32'd0);
        check({tag, "_rst_halt"}, {31'b0, halt}, 32'd0);
        check({tag, "_rst_ret"}, {31'b0, retire}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        ret_q.delete();
        fetch_q.delete();
        halt_cyc      = -1;
        first_req_cyc = -1;
        st_cycles     = 0;
        st_addr_first = 32'hFFFF_FFFF;
        st_data_first = 32'hFFFF_FFFF;
        st_addr_last  = 32'hFFFF_FFFF;
    endtask

    // Cycle 1 is the first cycle after the reset edge
    task automatic run_cycles(input int n);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (retire) ret_q.push_back(c);
            if (pmem_req && pmem_rvalid) fetch_q.push_back(pmem_addr);
            if (pmem_req && first_req_cyc < 0) first_req_cyc = c;
            if (halt && halt_cyc < 0) halt_cyc = c;
            if (dmem_req && dmem_we) begin
                if (st_cycles == 0) begin
                    st_addr_first = dmem_addr;
                    st_data_first = dmem_wdata;
                end
                st_addr_last = dmem_addr;
                st_cycles++;
            end
        end
    endtask

    initial begin
        // addi x1,x0,5 ; add x2,x1,x1 ; illegal
        clear_mem();
        imem[0] = 32'h0050_0093;
        imem[1] = 32'h0010_8133;
        do_reset("t1");
        run_cycles(14);
        check("t1_first_req", first_req_cyc, 1);
        check("t1_ret0", ret_at(0), 4);
        check("t1_ret1", ret_at(1), 8);
        check("t1_nret", ret_q.size(), 2);
        check("t1_fetch0", fetch_at(0), 32'h0);
        check("t1_fetch1", fetch_at(1), 32'h4);
        check("t1_x1", u_dut.u_rf.r_mem[1], 32'd5);
        check("t1_x2", u_dut.u_rf.r_mem[2], 32'd10);
        check("t1_halt_cyc", halt_cyc, 11);
        check("t1_nfetch", fetch_q.size(), 3);

        // addi x2,x0,10 ; sw x2,8(x0) ; lw x3,8(x0) with two dmem wait cycles
        clear_mem();
        imem[0] = 32'h00A0_0113;
        imem[1] = 32'h0020_2423;
        imem[2] = 32'h0080_2183;
        d_wait  = 2;
        do_reset("t2");
        run_cycles(20);
        check("t2_st_addr", st_addr_first, 32'd8);
        check("t2_st_data", st_data_first, 32'd10);
        check("t2_st_addr_held", st_addr_last, 32'd8);
        check("t2_we_cycles", st_cycles, 3);
        check("t2_ret_sw", ret_at(1), 10);
        check("t2_ret_lw", ret_at(2), 17);
        check("t2_mem8", dmem[2], 32'd10);
        check("t2_x3", u_dut.u_rf.r_mem[3], 32'd10);
        check("t2_halt_cyc", halt_cyc, 20);
        d_wait = 0;

        // bne x1,x1,+8 (not taken) ; beq x1,x1,-4 (taken): loops 0,4,0,4
        clear_mem();
        imem[0] = 32'h0010_9463;
        imem[1] = 32'hFE10_8EE3;
        do_reset("t3");
        run_cycles(12);
        check("t3_ret0", ret_at(0), 3);
        check("t3_ret1", ret_at(1), 6);
        check("t3_ret3", ret_at(3), 12);
        check("t3_fetch1", fetch_at(1), 32'h4);
        check("t3_fetch2", fetch_at(2), 32'h0);
        check("t3_fetch3", fetch_at(3), 32'h4);
        check("t3_halt", {31'b0, halt}, 32'd0);

        // four nops, jal x1,+12 @0x10, jalr x0,0(x1) @0x1C, jalr x0,2(x1) @0x14 (misaligned)
        clear_mem();
        for (int i = 0; i < 4; i++) imem[i] = 32'h0000_0013;
        imem[4] = 32'h00C0_00EF;
        imem[7] = 32'h0000_8067;
        imem[5] = 32'h0020_8067;
        do_reset("t4");
        run_cycles(32);
        check("t4_x1", u_dut.u_rf.r_mem[1], 32'h14);
        check("t4_ret_jal", ret_at(4), 19);
        check("t4_fetch_tgt", fetch_at(5), 32'h1C);
        check("t4_fetch_ret", fetch_at(6), 32'h14);
        check("t4_nfetch", fetch_q.size(), 7);
        check("t4_nret", ret_q.size(), 6);
        check("t4_halt_cyc", halt_cyc, 26);
        check("t4_preq_halted", {31'b0, pmem_req}, 32'd0);

        // illegal opcode at boot; halt is sticky until reset
        clear_mem();
        do_reset("t5");
        run_cycles(6);
        check("t5_halt_cyc", halt_cyc, 3);
        check("t5_halt_sticky", {31'b0, halt}, 32'd1);
        check("t5_nfetch", fetch_q.size(), 1);
        do_reset("t5b");
        run_cycles(2);
        check("t5b_refetch", fetch_at(0), 32'h0);
        check("t5b_first_req", first_req_cyc, 1);

        // reset while a fetch is waiting; fetch restarts at boot with 3 wait cycles
        clear_mem();
        imem[0] = 32'h0050_0093;
        p_wait  = 3;
        do_reset("t6");
        run_cycles(2);
        check("t6_wait_nofetch", fetch_q.size(), 0);
        do_reset("t6b");
        run_cycles(9);
        check("t6b_first_req", first_req_cyc, 1);
        check("t6b_fetch0", fetch_at(0), 32'h0);
        check("t6b_ret0", ret_at(0), 7);
        check("t6b_x1", u_dut.u_rf.r_mem[1], 32'd5);
        p_wait = 0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
